// File: rtl/seg_pkg.sv
// Shared glyph table and nibble-to-glyph helper for the 7-segment scan controller.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high (1 = segment on).
package seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_ERR   = GLYPH_E;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // Decimal digits always decode normally; 10..15 show hex letters only
    // when hex display is enabled, otherwise they fall back to the error glyph.
    function automatic logic [6:0] seg_glyph(input logic [3:0] nibble, input logic hex_en);
        logic [6:0] glyph;
        glyph = GLYPH_BLANK;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = hex_en ? GLYPH_A : GLYPH_ERR;
            4'hB: glyph = hex_en ? GLYPH_B : GLYPH_ERR;
            4'hC: glyph = hex_en ? GLYPH_C : GLYPH_ERR;
            4'hD: glyph = hex_en ? GLYPH_D : GLYPH_ERR;
            4'hE: glyph = hex_en ? GLYPH_E : GLYPH_ERR;
            default: glyph = hex_en ? GLYPH_F : GLYPH_ERR;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational decode of one digit (nibble + decimal point) into an
// active-high segment word {dp,g,f,e,d,c,b,a}. Polarity is handled by the caller.
module seg_glyph_dec
    import seg_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Decimal point rides on the top bit, glyph below it
    always_comb begin
        seg_o = {dp_i, seg_glyph(nibble_i, HEX_EN)};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: latches per-digit nibbles and decimal
// points, then time-multiplexes them onto shared segment lines with PWM
// brightness, per-digit blink, leading-zero blanking and an anti-ghost guard.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SEG_NUM    = 8,
    parameter int SCAN_CYC   = 1024,
    parameter int GUARD_CYC  = 2,
    parameter int BRIGHT_WID = 4,
    parameter int BLINK_FRM  = 32,
    parameter int HEX_EN     = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_NUM*4-1:0]    din,
    input  logic [SEG_NUM-1:0]      din_vld,
    input  logic [SEG_NUM-1:0]      dp,
    input  logic [SEG_NUM-1:0]      blink_mask,
    input  logic                    blank_lz,
    input  logic [BRIGHT_WID-1:0]   brightness,
    output logic [SEG_NUM-1:0]      seg_sel,
    output logic [7:0]              segment,
    output logic                    frame_done
);

    localparam int   IDX_W  = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;
    localparam int   SLOT_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int   FRM_W  = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;
    localparam int   STEP   = SCAN_CYC >> BRIGHT_WID;
    localparam logic POL    = (ACTIVE_LOW != 0);

    // Reject parameter sets that would make the slot timing meaningless
    if (SEG_NUM < 1 || SEG_NUM > 16 || BRIGHT_WID < 1 || BLINK_FRM < 1 ||
        GUARD_CYC < 0 || SCAN_CYC <= GUARD_CYC ||
        (SCAN_CYC % (1 << BRIGHT_WID)) != 0) begin : g_param_check
        $error("seg_scan_ctrl: illegal parameter combination");
    end

    logic [3:0]            nib_q [SEG_NUM];
    logic [SEG_NUM-1:0]    dp_q;
    logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRM_W-1:0]      frm_cnt_q, frm_cnt_d;
    logic                  blink_on_q, blink_on_d;
    logic [BRIGHT_WID-1:0] bright_q, bright_d;
    logic [SEG_NUM-1:0]    sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;

    logic                  slot_end, last_digit, frame_end, frame_start;
    logic [SEG_NUM-1:0]    lz_blank;
    logic                  zero_run;
    logic [BRIGHT_WID-1:0] bright_eff;
    logic [31:0]           on_thr;
    logic                  pwm_on, lit;
    logic [7:0]            dec_seg;

    assign slot_end    = (slot_cnt_q == SLOT_W'(SCAN_CYC - 1));
    assign last_digit  = (idx_q == IDX_W'(SEG_NUM - 1));
    assign frame_end   = slot_end && last_digit;
    assign frame_start = (slot_cnt_q == '0) && (idx_q == '0);
    assign frame_done  = frame_end;

    // Per-digit load: each strobe captures its own nibble and decimal point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEG_NUM; i++) nib_q[i] <= 4'h0;
            dp_q <= '0;
        end else begin
            for (int i = 0; i < SEG_NUM; i++) begin
                if (din_vld[i]) begin
                    nib_q[i] <= din[4*i +: 4];
                    dp_q[i]  <= dp[i];
                end
            end
        end
    end

    // Slot/digit/frame counters, blink phase toggle and frame-start brightness capture
    always_comb begin
        slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        frm_cnt_d  = frm_cnt_q;
        blink_on_d = blink_on_q;
        bright_d   = frame_start ? brightness : bright_q;
        if (slot_end) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            if (frm_cnt_q == FRM_W'(BLINK_FRM - 1)) begin
                frm_cnt_d  = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while everything seen is zero with no dp
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = SEG_NUM - 1; i >= 1; i--) begin
            zero_run    = zero_run && (nib_q[i] == 4'h0) && !dp_q[i];
            lz_blank[i] = blank_lz && zero_run;
        end
    end

    seg_glyph_dec #(
        .HEX_EN (HEX_EN != 0)
    ) u_dec (
        .nibble_i (nib_q[idx_q]),
        .dp_i     (dp_q[idx_q]),
        .seg_o    (dec_seg)
    );

    // Lit decision and output word; the frame-start cycle already uses the incoming brightness
    always_comb begin
        bright_eff = frame_start ? brightness : bright_q;
        on_thr     = 32'(bright_eff) * 32'(STEP);
        pwm_on     = (32'(slot_cnt_q) >= 32'(GUARD_CYC)) &&
                     ((&bright_eff) || (32'(slot_cnt_q) < on_thr));
        lit        = pwm_on && !(blink_mask[idx_q] && !blink_on_q) && !lz_blank[idx_q];
        sel_d      = lit ? (SEG_NUM'(1) << idx_q) : '0;
        seg_d      = lit ? dec_seg : 8'h00;
        sel_d      = sel_d ^ {SEG_NUM{POL}};
        seg_d      = seg_d ^ {8{POL}};
    end

    // State and output registers; reset drives the pins to their inactive level immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            frm_cnt_q  <= '0;
            blink_on_q <= 1'b1;
            bright_q   <= '0;
            sel_q      <= {SEG_NUM{POL}};
            seg_q      <= {8{POL}};
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            frm_cnt_q  <= frm_cnt_d;
            blink_on_q <= blink_on_d;
            bright_q   <= bright_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign seg_sel = sel_q;
    assign segment = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 64-cycle slots, active-low pins.
// Instance A decodes hex letters, instance B shows the error glyph for 10..15.
module tb_seg_scan_ctrl;

    localparam int SEG_NUM = 4;
    localparam logic [3:0] DARK_SEL = 4'hF;
    localparam logic [7:0] DARK_SEG = 8'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic [3:0]  din_vld = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink_mask = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'hF;

    logic [3:0]  selA, selB;
    logic [7:0]  segA, segB;
    logic        fdA, fdB;

    typedef struct {
        string      tag;
        logic [3:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t sbq[$];
    int   nCompared = 0;
    int   nMismatched = 0;
    int   cyc;

    seg_scan_ctrl #(
        .SEG_NUM(SEG_NUM), .SCAN_CYC(64), .GUARD_CYC(2), .BRIGHT_WID(4),
        .BLINK_FRM(2), .HEX_EN(1), .ACTIVE_LOW(1)
    ) dutA (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dp(dp),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .brightness(brightness),
        .seg_sel(selA), .segment(segA), .frame_done(fdA)
    );

    seg_scan_ctrl #(
        .SEG_NUM(SEG_NUM), .SCAN_CYC(64), .GUARD_CYC(2), .BRIGHT_WID(4),
        .BLINK_FRM(2), .HEX_EN(0), .ACTIVE_LOW(1)
    ) dutB (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dp(dp),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .brightness(brightness),
        .seg_sel(selB), .segment(segB), .frame_done(fdB)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release; edge k shows slot position k-1
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Drive all inputs; a load strobe is held for exactly one clock edge
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] v, input logic [3:0] p,
                                 input logic [3:0] bm, input logic lz, input logic [3:0] br);
        din        = d;
        din_vld    = v;
        dp         = p;
        blink_mask = bm;
        blank_lz   = lz;
        brightness = br;
        if (v != 4'h0) begin
            @(negedge clk);
            din_vld = 4'h0;
        end
    endtask

    // Park on the falling edge after rising edge k
    task automatic gotoCycle(input int k);
        if (cyc > k) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL schedule: at cycle %0d, required cycle %0d", cyc, k);
        end
        while (cyc < k) @(negedge clk);
    endtask

    // Pop the oldest expectation and compare it against the observed pins
    task automatic checkOutput(input logic [3:0] selObs, input logic [7:0] segObs);
        exp_t e;
        if (sbq.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL scoreboard: empty queue");
            return;
        end
        e = sbq.pop_front();
        nCompared++;
        assert (selObs === e.sel) else begin
            nMismatched++;
            $error("[TB] FAIL %s seg_sel: observed %h expected %h", e.tag, selObs, e.sel);
        end
        nCompared++;
        assert (segObs === e.seg) else begin
            nMismatched++;
            $error("[TB] FAIL %s segment: observed %h expected %h", e.tag, segObs, e.seg);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        nCompared++;
        assert (obs === expv) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Queue an expectation, run to cycle k, then compare instance A (or B)
    task automatic expectOut(input string tag, input int k, input logic [3:0] sel,
                             input logic [7:0] seg, input logic useB);
        sbq.push_back('{tag, sel, seg});
        gotoCycle(k);
        if (useB) checkOutput(selB, segB);
        else      checkOutput(selA, segA);
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);

        // Reset state on both instances
        sbq.push_back('{"rst_A", DARK_SEL, DARK_SEG});
        checkOutput(selA, segA);
        sbq.push_back('{"rst_B", DARK_SEL, DARK_SEG});
        checkOutput(selB, segB);
        checkBit("rst_frame_done", fdA, 1'b0);

        // Digits 3..0 = 1,2,3,4 at full brightness
        rst = 1'b0;
        applyStimulus(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 4'hF);
        expectOut("guard0", 1, DARK_SEL, DARK_SEG, 1'b0);
        expectOut("guard1", 2, DARK_SEL, DARK_SEG, 1'b0);
        expectOut("d0_first_lit", 3, 4'b1110, 8'h99, 1'b0);
        expectOut("d0_last_lit", 64, 4'b1110, 8'h99, 1'b0);
        expectOut("d1_guard", 65, DARK_SEL, DARK_SEG, 1'b0);
        expectOut("d1_three", 67, 4'b1101, 8'hB0, 1'b0);
        expectOut("d2_two", 131, 4'b1011, 8'hA4, 1'b0);
        expectOut("d3_one", 195, 4'b0111, 8'hF9, 1'b0);
        gotoCycle(254);
        checkBit("fd_before", fdA, 1'b0);
        gotoCycle(255);
        checkBit("fd_pulse", fdA, 1'b1);
        gotoCycle(256);
        checkBit("fd_after", fdA, 1'b0);

        // Brightness 4 set mid-frame 1 only takes effect in frame 2
        gotoCycle(260);
        applyStimulus(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'h4);
        expectOut("bright_hold_a", 323, 4'b1101, 8'hB0, 1'b0);
        expectOut("bright_hold_b", 340, 4'b1101, 8'hB0, 1'b0);
        expectOut("pwm_slot2", 515, 4'b1110, 8'h99, 1'b0);
        expectOut("pwm_slot15", 528, 4'b1110, 8'h99, 1'b0);
        expectOut("pwm_slot16", 529, DARK_SEL, DARK_SEG, 1'b0);
        expectOut("pwm_d1_slot15", 592, 4'b1101, 8'hB0, 1'b0);
        expectOut("pwm_d1_slot16", 593, DARK_SEL, DARK_SEG, 1'b0);
        gotoCycle(600);
        applyStimulus(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        expectOut("bright0_midframe", 650, 4'b1011, 8'hA4, 1'b0);
        expectOut("bright0_dark", 774, DARK_SEL, DARK_SEG, 1'b0);
        gotoCycle(800);
        applyStimulus(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
        expectOut("bright0_hold", 843, DARK_SEL, DARK_SEG, 1'b0);

        // Leading-zero blanking with digits 3..0 = 0,0,7,0
        gotoCycle(1030);
        applyStimulus(16'h0070, 4'hF, 4'h0, 4'h0, 1'b1, 4'hF);
        expectOut("lz_d0_zero", 1040, 4'b1110, 8'hC0, 1'b0);
        expectOut("lz_d1_seven", 1099, 4'b1101, 8'hF8, 1'b0);
        expectOut("lz_d2_blank", 1163, DARK_SEL, DARK_SEG, 1'b0);
        expectOut("lz_d3_blank", 1227, DARK_SEL, DARK_SEG, 1'b0);
        gotoCycle(1285);
        applyStimulus(16'h0070, 4'b0100, 4'b0100, 4'h0, 1'b1, 4'hF);
        expectOut("lz_d2_dp", 1419, 4'b1011, 8'h40, 1'b0);
        expectOut("lz_d3_still", 1483, DARK_SEL, DARK_SEG, 1'b0);

        // Blink on digit 0: phase is on for frames 0-1, off 2-3, on 4-5, ...
        gotoCycle(1540);
        applyStimulus(16'h0070, 4'h0, 4'b0100, 4'b0001, 1'b1, 4'hF);
        expectOut("blink_f6_off", 1547, DARK_SEL, DARK_SEG, 1'b0);
        expectOut("blink_f6_d1", 1611, 4'b1101, 8'hF8, 1'b0);
        expectOut("blink_f7_off", 1803, DARK_SEL, DARK_SEG, 1'b0);
        expectOut("blink_f8_on", 2059, 4'b1110, 8'hC0, 1'b0);
        expectOut("blink_f9_on", 2315, 4'b1110, 8'hC0, 1'b0);
        expectOut("blink_f10_off", 2571, DARK_SEL, DARK_SEG, 1'b0);

        // Nibble B: hex letter on A, error glyph on B
        gotoCycle(2830);
        applyStimulus(16'h007B, 4'b0001, 4'b0100, 4'h0, 1'b1, 4'hF);
        expectOut("hex_b_on", 2840, 4'b1110, 8'h83, 1'b0);
        expectOut("hex_b_off", 2840, 4'b1110, 8'h86, 1'b1);

        // Reset mid-slot: pins go dark before the next edge, scan restarts at digit 0
        expectOut("pre_reset", 3160, 4'b1101, 8'hF8, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sbq.push_back('{"async_rst", DARK_SEL, DARK_SEG});
        checkOutput(selA, segA);
        checkBit("async_rst_fd", fdA, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expectOut("post_rst_d0", 3, 4'b1110, 8'hC0, 1'b0);
        expectOut("post_rst_d1", 67, DARK_SEL, DARK_SEG, 1'b0);

        if (sbq.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL scoreboard_leftover: %0d entries, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
